// File: rtl/jk_response_checker.sv
// Response monitor for JK storage elements: predicts q from observed stimulus,
// compares against the element's q/qb and reports pulses, a sticky fail and counters.
module jk_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             dut_rst,
  input  logic             j,
  input  logic             k,
  input  logic             en,
  input  logic             q,
  input  logic             qb,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             comp_err,
  output logic             race,
  output logic             fail,
  output logic             first_err_q,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  typedef enum logic {UNK = 1'b0, TRK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             cmp_edge;
  logic             mm_now;
  logic             ce_now;
  logic             race_now;
  logic [1:0]       n_events;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] chk_next;

  // exp_valid is the FSM state bit itself, so it doubles as the state debug view.
  assign exp_valid = (state == TRK);

  always_comb begin
    cmp_edge = (state == TRK);
    mm_now   = cmp_edge && (q != exp_q);
    ce_now   = (qb == q);
    race_now = !dut_rst && en && j && k;
    n_events = {1'b0, mm_now} + {1'b0, ce_now};
    err_sum  = {1'b0, err_cnt} + (CNT_W+1)'(n_events);
    err_next = (err_sum > {1'b0, CNT_MAX}) ? CNT_MAX : err_sum[CNT_W-1:0];
    chk_next = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNK;
      exp_q       <= 1'b0;
      mismatch    <= 1'b0;
      comp_err    <= 1'b0;
      race        <= 1'b0;
      fail        <= 1'b0;
      first_err_q <= 1'b0;
      err_cnt     <= '0;
      chk_cnt     <= '0;
    end else begin
      // Prediction: dut_rst dominates; j=k=1 with en loses track of q.
      if (dut_rst) begin
        exp_q <= 1'b0;
        state <= TRK;
      end else if (en && j && k) begin
        state <= UNK;
      end else if (en && (j != k)) begin
        exp_q <= j;
        state <= TRK;
      end

      mismatch <= mm_now;
      comp_err <= ce_now;
      race     <= race_now;

      if (clr) begin
        err_cnt     <= '0;
        chk_cnt     <= '0;
        fail        <= 1'b0;
        first_err_q <= 1'b0;
      end else begin
        if (mm_now && !fail) first_err_q <= q;
        if (mm_now || ce_now) fail <= 1'b1;
        err_cnt <= err_next;
        if (cmp_edge) chk_cnt <= chk_next;
      end
    end
  end

endmodule

// File: tb/tb_jk_response_checker.sv
// Bench for jk_response_checker: directed scenarios then random stimulus, all
// checked against a clamped-integer reference model of the checking rules.
module tb_jk_response_checker;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             dut_rst = 1'b0;
  logic             j = 1'b0;
  logic             k = 1'b0;
  logic             en = 1'b0;
  logic             q = 1'b0;
  logic             qb = 1'b1;
  logic             exp_q;
  logic             exp_valid;
  logic             mismatch;
  logic             comp_err;
  logic             race;
  logic             fail;
  logic             first_err_q;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: prediction known/unknown, predicted value, unbounded counts.
  bit m_trk, m_q, m_mm, m_ce, m_race, m_fail, m_first;
  int m_err, m_chk;

  jk_response_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .dut_rst(dut_rst),
    .j(j), .k(k), .en(en), .q(q), .qb(qb),
    .exp_q(exp_q), .exp_valid(exp_valid), .mismatch(mismatch),
    .comp_err(comp_err), .race(race), .fail(fail),
    .first_err_q(first_err_q), .err_cnt(err_cnt), .chk_cnt(chk_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_reset();
    m_trk = 0; m_q = 0; m_mm = 0; m_ce = 0; m_race = 0;
    m_fail = 0; m_first = 0; m_err = 0; m_chk = 0;
  endtask

  task automatic model_edge(input bit d_rst, input bit jj, input bit kk,
                            input bit ee, input bit qq, input bit qqb, input bit cl);
    bit cmp, mm, ce;
    cmp = m_trk;
    mm  = cmp && (qq != m_q);
    ce  = (qqb == qq);
    m_race = !d_rst && ee && jj && kk;
    if (d_rst) begin
      m_q = 0; m_trk = 1;
    end else if (ee && jj && kk) begin
      m_trk = 0;
    end else if (ee && (jj != kk)) begin
      m_q = jj; m_trk = 1;
    end
    m_mm = mm;
    m_ce = ce;
    if (cl) begin
      m_err = 0; m_chk = 0; m_fail = 0; m_first = 0;
    end else begin
      if (mm && !m_fail) m_first = qq;
      if (mm || ce) m_fail = 1;
      m_err += int'(mm) + int'(ce);
      m_chk += int'(cmp);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".exp_q"},       8'(exp_q),       8'(m_q));
    chk({tag, ".exp_valid"},   8'(exp_valid),   8'(m_trk));
    chk({tag, ".mismatch"},    8'(mismatch),    8'(m_mm));
    chk({tag, ".comp_err"},    8'(comp_err),    8'(m_ce));
    chk({tag, ".race"},        8'(race),        8'(m_race));
    chk({tag, ".fail"},        8'(fail),        8'(m_fail));
    chk({tag, ".first_err_q"}, 8'(first_err_q), 8'(m_first));
    chk({tag, ".err_cnt"},     8'(err_cnt),     8'(sat(m_err)));
    chk({tag, ".chk_cnt"},     8'(chk_cnt),     8'(sat(m_chk)));
  endtask

  // One clock edge of stimulus; outputs are checked 1 ns after the edge.
  task automatic step(input string tag, input bit d_rst, input bit ee, input bit jj,
                      input bit kk, input bit qq, input bit qqb, input bit cl);
    @(negedge clk);
    dut_rst = d_rst; en = ee; j = jj; k = kk; q = qq; qb = qqb; clr = cl;
    @(posedge clk);
    model_edge(d_rst, jj, kk, ee, qq, qqb, cl);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit rq, rqb;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset and settle.
    step("settle_rst", 1, 0, 0, 0, 0, 1, 0);
    step("settle_hold", 0, 0, 0, 0, 0, 1, 0);

    // Defined sequence with a correct DUT: q follows exp_q one edge later.
    step("seq_01", 0, 1, 0, 1, m_q, ~m_q, 0);
    step("seq_00", 0, 1, 0, 0, m_q, ~m_q, 0);
    step("seq_01b", 0, 1, 0, 1, m_q, ~m_q, 0);
    step("seq_10", 0, 1, 1, 0, m_q, ~m_q, 0);

    // Fault injection: q stuck at 0 after exp_q became 1.
    step("fault_1", 0, 1, 0, 0, 0, 1, 0);
    step("fault_2", 0, 1, 0, 0, 0, 1, 0);
    step("clr_a", 0, 1, 0, 0, m_q, ~m_q, 1);

    // Race: tracking lost, then regained by jk=01.
    step("race", 0, 1, 1, 1, m_q, ~m_q, 0);
    step("race_unk", 0, 1, 0, 0, 1, 0, 0);
    step("race_def", 0, 1, 0, 1, 1, 0, 0);
    step("race_resume", 0, 0, 0, 0, m_q, ~m_q, 0);

    // Complement error plus mismatch every edge, driving err_cnt to saturation.
    for (int i = 0; i < 5; i++) step("sat", 0, 0, 0, 0, ~m_q, ~m_q, 0);
    step("clr_b", 0, 0, 0, 0, m_q, ~m_q, 1);
    step("after_clr", 0, 0, 0, 0, m_q, ~m_q, 0);

    // dut_rst has priority over a simultaneous race condition.
    step("prio_set", 0, 1, 1, 0, m_q, ~m_q, 0);
    step("prio", 1, 1, 1, 1, m_q, ~m_q, 0);
    step("prio_next", 0, 0, 0, 0, m_q, ~m_q, 0);

    // Asynchronous reset between edges.
    step("pre_async_err", 0, 0, 0, 0, ~m_q, m_q, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      bit rd, re, rj, rk, rc;
      rd = ($urandom_range(0, 15) == 0);
      re = ($urandom_range(0, 3) != 0);
      rj = 1'($urandom);
      rk = 1'($urandom);
      rc = ($urandom_range(0, 24) == 0);
      rq  = m_trk ? m_q : 1'($urandom);
      if ($urandom_range(0, 7) == 0) rq = ~rq;
      rqb = ($urandom_range(0, 9) == 0) ? rq : ~rq;
      step("rand", rd, re, rj, rk, rq, rqb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_response_checker.md
# jk_response_checker

Synthesizable, self-checking response monitor for the JK latch/flip-flop family: it observes the same j, k, en and DUT-reset stimulus that drives a JK storage element, predicts the expected q from that stimulus, and compares it against the element's observed q and qb. It is the consuming end of the JK stimulus path. It sits beside the DUT in benches and on-chip BIST wrappers, and reports per-cycle mismatches, races, a sticky fail flag and saturating counters.

## Interface
- CNT_W, 8, width of the err_cnt and chk_cnt counters.
- clk  input  1  sampling clock; all state updates on the rising edge.
- rst  input  1  checker reset; asynchronous, active-high.
- clr  input  1  synchronous clear of the counters, fail and first_err_q; does not affect the prediction state.
- dut_rst  input  1  observed reset of the monitored element.
- j  input  1  observed J.
- k  input  1  observed K.
- en  input  1  observed enable.
- q  input  1  observed DUT output.
- qb  input  1  observed DUT complementary output.
- exp_q  output  1  predicted q; meaningful only while exp_valid=1.
- exp_valid  output  1  1 in state TRK.
- mismatch  output  1  one-cycle pulse: q != exp_q on a compare edge.
- comp_err  output  1  one-cycle pulse: qb != ~q on any edge after reset.
- race  output  1  one-cycle pulse: en=j=k=1 sampled with dut_rst=0.
- fail  output  1  sticky; set by mismatch or comp_err.
- first_err_q  output  1  q value captured at the first mismatch.
- err_cnt  output  CNT_W  saturating count of mismatch plus comp_err events.
- chk_cnt  output  CNT_W  saturating count of compare edges.

## Operation
- Two-state FSM: UNK (prediction unknown) and TRK (tracking).
- Prediction update on each edge, from the inputs sampled at that edge:
  - dut_rst=1: exp_q<=0, go to TRK. This has priority over en, j and k, and race is not pulsed.
  - en=0, or j=k=0: exp_q holds and the state holds.
  - en=1, j=0, k=1: exp_q<=0, go to TRK.
  - en=1, j=1, k=0: exp_q<=1, go to TRK.
  - en=1, j=k=1: race pulses and the state goes to UNK. Level-sensitive toggle is a race condition, so the result is not predictable. exp_q holds its last value.
- Compare: on an edge where the state before the edge is TRK, compare the sampled q with exp_q as registered before that edge.
  - chk_cnt increments.
  - On inequality, mismatch pulses. If fail was 0, first_err_q<=q.
- The complement check (qb == ~q) runs on every edge in both states.
- err_cnt increases by the number of events on that edge (0, 1 or 2) and saturates at 2^CNT_W-1. chk_cnt also saturates.
- fail is set by either event and stays set until rst or clr.
- clr=1 on an edge:
  - err_cnt, chk_cnt, fail and first_err_q <= 0.
  - Events on that same edge are not counted and do not set fail.
  - FSM and exp_q update normally.

## Timing
- All outputs are registered. The DUT is required to settle within one clk period of an input change.
- Latency:
  - Stimulus sampled at edge n is applied to exp_q at edge n.
  - The DUT response to that stimulus is checked at edge n+1.
  - mismatch is visible from edge n+1 until edge n+2.
- Reset values: state UNK; exp_q, exp_valid, mismatch, comp_err, race, fail, first_err_q = 0; err_cnt = 0; chk_cnt = 0.
- Reset behaviour: rst asserted mid-run clears everything immediately, independent of clk. The first edge after rst is released evaluates normally.
- UNK to TRK transition edge: no compare on that edge. The first compare is on the next edge.
- TRK to UNK (race) edge: the compare still happens on that edge, using the old exp_q. From the following edge no compares occur until a defining event.

## Test plan
- Reset and settle: rst=1, then release; dut_rst=1 for one edge; q=0, qb=1 -> exp_valid=1 and exp_q=0 from the next edge; mismatch=0; chk_cnt increments by 1 per edge.
- Defined sequence with a correct DUT: en=1 with jk 01, 00, 01, 10, each held one edge, q following one edge later -> mismatch never pulses; fail=0; exp_q sequence 0,0,0,1.
- Fault injection: after jk=10, hold q=0 for one edge -> mismatch pulses once; fail=1; first_err_q=0; err_cnt=1; with q still stuck the next edge, err_cnt=2.
- Race: en=1, j=k=1 for one edge -> race pulses; exp_valid=0 from the following edge; chk_cnt frozen; jk=01 -> TRK again and compares resume one edge later.
- Complement and saturation: CNT_W=2; force qb=q and q!=exp_q for 5 edges -> comp_err and mismatch pulse every edge; err_cnt stops at 3; clr=1 -> counters=0, fail=0.
- Priority and async reset: dut_rst=1 with en=j=k=1 -> no race; exp_q=0; state TRK. rst asserted between edges -> all outputs 0 before the next edge.
